fcvt_int_sched: RTL
===================

// Module: fcvt_int_sched
// PURPOSE
//   Shared, multi-cycle integer-to-single conversion unit (fcvt.s.w / fcvt.s.wu) with a
//   round-robin arbiter in front. NREQ issue ports request conversions over valid/ready.
//   One request is granted at a time and normalised iteratively, rounded RNE, and
//   returned over a valid/ready result port tagged with requester id and tag.
// PARAMETERS
//   NREQ   2  number of requesters (>=2)
//   TAG_W  5  request tag width (typically rd index), returned unchanged
//   ID_W   $clog2(NREQ)  width of res_id (localparam, not overridable)
// PORTS
//   clk         in   1           clock, rising edge
//   resetn      in   1           asynchronous active-low reset
//   req_valid   in   NREQ        per-requester request valid
//   req_ready   out  NREQ        per-requester accept (one-hot or zero)
//   req_op      in   NREQ*32     operand; requester i at [32*i+31:32*i]
//   req_signed  in   NREQ        1 = fcvt.s.w (two's complement), 0 = fcvt.s.wu
//   req_tag     in   NREQ*TAG_W  tag; requester i at [TAG_W*i+TAG_W-1:TAG_W*i]
//   res_valid   out  1           result valid, held until res_ready
//   res_ready   in   1           consumer accept
//   res_data    out  32          IEEE-754 single result
//   res_id      out  ID_W        index of granted requester
//   res_tag     out  TAG_W       tag of granted request
//   res_nx      out  1           inexact flag (guard|sticky nonzero)
// BEHAVIOUR
//   Reset: state=IDLE, rr pointer=0, res_valid=0, res_data=0, res_id=0, res_tag=0, res_nx=0.
//   req_ready: combinational; only in IDLE, one-hot to first valid requester searching from
//     rr pointer upward with wrap; all zero outside IDLE. Accept = req_valid[i]&req_ready[i].
//   States: IDLE, NORM, ROUND, DONE.
//   IDLE on accept: latch id/tag; sign = signed & op[31]; mag = sign ? -op : op (32b wrap,
//     so 0x80000000 stays 0x80000000); e = 31. mag==0 -> DONE with res_data=0x00000000, nx=0;
//     else -> NORM.
//   NORM, one step per cycle: mag[31]=1 -> ROUND (no shift); else mag[31:24]==0 -> mag<<=8,
//     e-=8; else mag<<=1, e-=1. Stay in NORM.
//   ROUND: m = mag[30:8], g = mag[7], s = |mag[6:0]; inc = g & (s | m[0]); m+inc carrying
//     out of bit 22 -> m=0, e+=1. res_data = {sign, e+127 (8b), m}; res_nx = g|s -> DONE.
//     No overflow possible (max e=31 -> 0x4F800000 after carry).
//   DONE: res_valid=1, outputs stable; on res_ready -> IDLE, res_valid=0, rr pointer =
//     granted id+1 (mod NREQ). res_data/id/tag/nx hold last value when res_valid=0.
//   Latency: n shifts -> res_valid rises n+2 cycles after accept edge; zero operand: 1 cycle.
//     Worst case op=1: n=10 -> 12 cycles. Throughput: one conversion in flight.
//   Requests not granted must hold; unit never drops an accepted request.
//   Reset mid-operation: async to IDLE values above; in-flight request discarded, no result.
// TESTING
//   wu op=1 from req0 -> res_data=0x3F800000, nx=0, res_valid 12 cycles after accept.
//   wu 0xFFFFFFFF -> 0x4F800000 nx=1 (round carry); w 0xFFFFFFFF -> 0xBF800000 nx=0.
//   wu 0x01000001 -> 0x4B800000 nx=1 (tie to even); w 0x80000000 -> 0xCF000000 nx=0; op=0 -> 0x0, 1-cycle.
//   req0,req1 valid together out of reset, tags 3,7 -> req1 gated; req0 then req1 served
//     (res_id 0 then 1); re-request both -> req0 next (rr pointer wrapped to 0).
//   res_ready low 5 cycles in DONE -> res_valid and all res_* stable, req_ready=0 throughout.
//   resetn low during NORM -> res_valid=0 immediately; no result after release; next request normal.

Source files
------------

// File: rtl/fcvt_int_sched.sv
// Shared iterative int32/uint32 -> IEEE-754 single converter (fcvt.s.w / fcvt.s.wu)
// behind a round-robin arbiter; one conversion in flight, result returned over valid/ready.
module fcvt_int_sched #(
    parameter int NREQ  = 2,
    parameter int TAG_W = 5,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*32-1:0]    req_op,
    input  logic [NREQ-1:0]       req_signed,
    input  logic [NREQ*TAG_W-1:0] req_tag,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_data,
    output logic [ID_W-1:0]       res_id,
    output logic [TAG_W-1:0]      res_tag,
    output logic                  res_nx
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    hi_id;
    logic [ID_W-1:0]    lo_id;
    logic               hi_hit;
    logic               lo_hit;
    logic               accept;
    logic [31:0]        gnt_op;
    logic               gnt_signed;
    logic [TAG_W-1:0]   gnt_tag;
    logic signed [31:0] op_s;
    logic               sign_in;
    logic [31:0]        mag_in;
    logic [31:0]        mag;
    logic [7:0]         exp_cnt;
    logic               sign;
    logic [ID_W-1:0]    cur_id;
    logic [TAG_W-1:0]   cur_tag;
    logic [32:0]        rounded;

    // Round-to-nearest-even on a normalised magnitude (mag[31] set); returns {nx, single}.
    function automatic logic [32:0] round_pack(input logic       s_bit,
                                               input logic [7:0]  e,
                                               input logic [31:0] m_in);
        logic [22:0] frac;
        logic        guard;
        logic        sticky;
        logic        inc;
        logic [23:0] frac_sum;
        logic [7:0]  e_adj;
        frac     = m_in[30:8];
        guard    = m_in[7];
        sticky   = |m_in[6:0];
        inc      = guard & (sticky | frac[0]);
        frac_sum = {1'b0, frac} + {23'd0, inc};
        e_adj    = frac_sum[23] ? e + 8'd1 : e;
        round_pack = {guard | sticky, s_bit, e_adj + 8'd127, frac_sum[22:0]};
    endfunction

    // Scanning downward leaves the lowest valid index in lo_id and the lowest at/above rr_ptr in hi_id.
    always_comb begin
        hi_id  = '0;
        lo_id  = '0;
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_id  = ID_W'(i);
                lo_hit = 1'b1;
                if (ID_W'(i) >= rr_ptr) begin
                    hi_id  = ID_W'(i);
                    hi_hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_id     = hi_hit ? hi_id : lo_id;
        req_ready  = '0;
        gnt_op     = '0;
        gnt_signed = 1'b0;
        gnt_tag    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == gnt_id) begin
                gnt_op     = req_op[32*i +: 32];
                gnt_signed = req_signed[i];
                gnt_tag    = req_tag[TAG_W*i +: TAG_W];
            end
        end
        if (state == IDLE && lo_hit) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign accept  = (state == IDLE) && lo_hit;
    assign op_s    = gnt_op;
    assign sign_in = gnt_signed & gnt_op[31];
    assign mag_in  = sign_in ? $unsigned(-op_s) : gnt_op;
    assign rounded = round_pack(sign, exp_cnt, mag);
    assign res_valid = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (mag_in == 32'd0) ? DONE : NORM;
            NORM:    if (mag[31]) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= '0;
        end else if (state == DONE && res_ready) begin
            rr_ptr <= (cur_id == ID_W'(NREQ - 1)) ? '0 : cur_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_data <= '0;
            res_nx   <= 1'b0;
            res_id   <= '0;
            res_tag  <= '0;
        end else if (accept && mag_in == 32'd0) begin
            res_data <= '0;
            res_nx   <= 1'b0;
            res_id   <= gnt_id;
            res_tag  <= gnt_tag;
        end else if (state == ROUND) begin
            res_data <= rounded[31:0];
            res_nx   <= rounded[32];
            res_id   <= cur_id;
            res_tag  <= cur_tag;
        end
    end

    // Normaliser: byte steps while the top byte is empty, then single-bit steps.
    always_ff @(posedge clk) begin
        if (accept) begin
            mag     <= mag_in;
            exp_cnt <= 8'd31;
            sign    <= sign_in;
            cur_id  <= gnt_id;
            cur_tag <= gnt_tag;
        end else if (state == NORM && !mag[31]) begin
            if (mag[31:24] == 8'd0) begin
                mag     <= mag << 8;
                exp_cnt <= exp_cnt - 8'd8;
            end else begin
                mag     <= mag << 1;
                exp_cnt <= exp_cnt - 8'd1;
            end
        end
    end

endmodule
